// File: rtl/mem_responder.sv
// mem_responder: serves single-word read/write request messages from a byte
// channel against a 32-bit synchronous RAM, one request at a time.
// Request byte 0 = {mask[3:0], rsvd[1:0], op[1:0]}, bytes 1-4 = byte address,
// bytes 5-8 = write data; all multi-byte fields little-endian.
// MESSAGE_BIT must be at least 72 so that a full write request fits.
module mem_responder #(
  parameter int MESSAGE_BIT = 72,
  parameter int ADDR_BIT    = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   COMM_readable,
  input  logic [MESSAGE_BIT-1:0] COMM_read_data,
  input  logic [4:0]             COMM_read_length,
  output logic                   COMM_read_flag,
  input  logic                   COMM_writable,
  output logic                   COMM_write_flag,
  output logic [MESSAGE_BIT-1:0] COMM_write_data,
  output logic [4:0]             COMM_write_length,
  output logic [ADDR_BIT-1:0]    ram_addr,
  output logic [3:0]             ram_we,
  output logic [31:0]            ram_wdata,
  input  logic [31:0]            ram_rdata
);

  // state | meaning
  // IDLE  | wait for a request; pop and capture it in the same cycle
  // LATCH | decode the captured request
  // READ  | present word address to the RAM
  // RWAIT | RAM data valid; load it into the response register
  // WRITE | single-cycle byte-masked RAM write
  // ERROR | load the error response
  // RESP  | hold the response; push it on the first writable cycle
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [1:0]             op_q;
  logic [3:0]             mask_q;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic [4:0]             len_q;
  logic [MESSAGE_BIT-1:0] resp_data_q, resp_data_d;
  logic [4:0]             resp_len_q, resp_len_d;
  logic                   take_req;
  logic                   addr_ok;
  logic                   is_read;
  logic                   is_write;
  logic                   unused_rsvd;

  // The pop is combinational so capture happens on the same edge; gating with
  // rst keeps the pop quiet while reset is held.
  assign take_req        = (state_q == S_IDLE) && COMM_readable && !rst;
  assign COMM_read_flag  = take_req;
  assign COMM_write_flag = (state_q == S_RESP) && COMM_writable;

  assign COMM_write_data   = resp_data_q;
  assign COMM_write_length = resp_len_q;

  // Byte 0 bits [3:2] carry no meaning.
  assign unused_rsvd = ^COMM_read_data[3:2];

  // Address must be word aligned and lie inside the attached RAM.
  assign addr_ok  = (addr_q[1:0] == 2'b00) && ((addr_q >> (ADDR_BIT + 2)) == 32'd0);
  assign is_read  = (op_q == 2'b01) && (len_q == 5'd5) && addr_ok;
  assign is_write = (op_q == 2'b10) && (len_q == 5'd9) && addr_ok;

  // Capture the head message on the pop cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
    end else if (take_req) begin
      op_q    <= COMM_read_data[1:0];
      mask_q  <= COMM_read_data[7:4];
      addr_q  <= COMM_read_data[39:8];
      wdata_q <= COMM_read_data[71:40];
      len_q   <= COMM_read_length;
    end
  end

  // Sequencing: one request in flight from pop to push.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take_req) state_d = S_LATCH;
      S_LATCH: begin
        if (is_read)       state_d = S_READ;
        else if (is_write) state_d = S_WRITE;
        else               state_d = S_ERROR;
      end
      S_READ:  state_d = S_RWAIT;
      S_RWAIT: state_d = S_RESP;
      S_WRITE: state_d = S_RESP;
      S_ERROR: state_d = S_RESP;
      S_RESP:  if (COMM_writable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response register loads once per request and is held through RESP.
  always_comb begin
    resp_data_d = resp_data_q;
    resp_len_d  = resp_len_q;
    case (state_q)
      S_RWAIT: begin
        resp_data_d        = '0;
        resp_data_d[31:0]  = ram_rdata;
        resp_len_d         = 5'd4;
      end
      S_WRITE: begin
        resp_data_d = '0;
        resp_len_d  = 5'd1;
      end
      S_ERROR: begin
        resp_data_d       = '0;
        resp_data_d[7:0]  = 8'hFF;
        resp_len_d        = 5'd1;
      end
      default: ;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      resp_data_q <= '0;
      resp_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_len_q  <= resp_len_d;
    end
  end

  // RAM port is decoded from state so reset silences it immediately.
  always_comb begin
    ram_addr  = '0;
    ram_we    = '0;
    ram_wdata = '0;
    case (state_q)
      S_READ:  ram_addr = addr_q[ADDR_BIT+1:2];
      S_WRITE: begin
        ram_addr  = addr_q[ADDR_BIT+1:2];
        ram_we    = mask_q;
        ram_wdata = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus a randomized request
// stream, checked every cycle against a transaction-level model.
module tb_mem_responder;

  localparam int MB = 72;
  localparam int AB = 17;
  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_ER = 2;

  typedef struct {
    logic [71:0] data;
    logic [4:0]  len;
  } req_t;

  logic          clk;
  logic          rst;
  logic          COMM_readable;
  logic [MB-1:0] COMM_read_data;
  logic [4:0]    COMM_read_length;
  logic          COMM_read_flag;
  logic          COMM_writable;
  logic          COMM_write_flag;
  logic [MB-1:0] COMM_write_data;
  logic [4:0]    COMM_write_length;
  logic [AB-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  mem_responder #(.MESSAGE_BIT(MB), .ADDR_BIT(AB)) dut (
    .clk               (clk),
    .rst               (rst),
    .COMM_readable     (COMM_readable),
    .COMM_read_data    (COMM_read_data),
    .COMM_read_length  (COMM_read_length),
    .COMM_read_flag    (COMM_read_flag),
    .COMM_writable     (COMM_writable),
    .COMM_write_flag   (COMM_write_flag),
    .COMM_write_data   (COMM_write_data),
    .COMM_write_length (COMM_write_length),
    .ram_addr          (ram_addr),
    .ram_we            (ram_we),
    .ram_wdata         (ram_wdata),
    .ram_rdata         (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // stimulus controls
  req_t req_q[$];
  logic rst_req;
  logic wr_en;
  logic rand_wr;

  // model state: at most one request in flight
  int          cyc = 0;
  logic        inf = 1'b0;
  int          cur_kind;
  logic [3:0]  cur_mask;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  int          pop_cyc;
  int          due;
  logic [71:0] exp_data;
  logic [4:0]  exp_len;

  // observations of the DUT, used by directed literal checks
  int          pop_log[$];
  logic [31:0] push_log[$];
  int          push_cnt = 0;
  int          push_cyc = 0;
  int          we_cnt = 0;
  logic [3:0]  last_we = 4'h0;
  logic [71:0] last_push_data = '0;
  logic [4:0]  last_push_len = '0;

  logic [31:0] menv [int unsigned];
  logic [31:0] mref [int unsigned];

  function automatic logic [31:0] env_rd(int unsigned a);
    if (menv.exists(a)) return menv[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(int unsigned a);
    if (mref.exists(a)) return mref[a];
    return 32'h0;
  endfunction

  // synchronous RAM: read data one cycle after the address, read-before-write
  always @(posedge clk) begin
    logic [31:0] w;
    ram_rdata <= env_rd(ram_addr);
    if (ram_we != 4'h0) begin
      w = env_rd(ram_addr);
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
      menv[ram_addr] = w;
    end
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read_flag"},  COMM_read_flag, 0);
    chk({tag, "_write_flag"}, COMM_write_flag, 0);
    chk({tag, "_write_data"}, COMM_write_data, 0);
    chk({tag, "_write_len"},  COMM_write_length, 0);
    chk({tag, "_ram_addr"},   ram_addr, 0);
    chk({tag, "_ram_we"},     ram_we, 0);
    chk({tag, "_ram_wdata"},  ram_wdata, 0);
  endtask

  function automatic req_t mk(logic [7:0] b0, logic [31:0] a, logic [31:0] d, logic [4:0] len);
    req_t r;
    r.data = {d, a, b0};
    r.len  = len;
    return r;
  endfunction

  function automatic req_t mk_read(logic [31:0] a);
    return mk(8'h01, a, 32'h0, 5'd5);
  endfunction

  function automatic req_t mk_write(logic [31:0] a, logic [31:0] d, logic [3:0] m);
    return mk({m, 4'h2}, a, d, 5'd9);
  endfunction

  // What a request means, from the message rules alone.
  task automatic model_accept(input req_t r);
    logic aok;
    cur_addr  = r.data[39:8];
    cur_wdata = r.data[71:40];
    cur_mask  = r.data[7:4];
    aok = (cur_addr % 4 == 0) && (64'(cur_addr) < (64'd1 << (AB + 2)));
    if (r.data[1:0] == 2'b01 && r.len == 5'd5 && aok) cur_kind = K_RD;
    else if (r.data[1:0] == 2'b10 && r.len == 5'd9 && aok) cur_kind = K_WR;
    else cur_kind = K_ER;
    pop_cyc = cyc;
    inf = 1'b1;
    if (cur_kind == K_RD) begin
      exp_data = {40'h0, ref_rd(cur_addr / 4)};
      exp_len  = 5'd4;
      due      = cyc + 4;
    end else begin
      exp_data = (cur_kind == K_WR) ? 72'h0 : 72'hFF;
      exp_len  = 5'd1;
      due      = cyc + 3;
    end
  endtask

  // Compare DUT outputs with the model for the current cycle.
  task automatic check_cycle();
    logic       exp_rf;
    logic       exp_wf;
    logic [3:0] exp_we;
    logic [31:0] w;
    cyc++;
    if (rst) begin
      chk_reset_outputs("in_reset");
      inf = 1'b0;
      return;
    end
    exp_rf = !inf && COMM_readable;
    exp_wf = inf && (cyc >= due) && COMM_writable;
    exp_we = (inf && cur_kind == K_WR && cyc == pop_cyc + 2) ? cur_mask : 4'h0;
    chk("read_flag", COMM_read_flag, exp_rf);
    chk("write_flag", COMM_write_flag, exp_wf);
    chk("flag_overlap", COMM_read_flag & COMM_write_flag, 0);
    chk("ram_we", ram_we, exp_we);
    if (inf && cur_kind != K_ER && cyc == pop_cyc + 2) begin
      chk("ram_addr", ram_addr, cur_addr[AB+1:2]);
      if (cur_kind == K_WR) chk("ram_wdata", ram_wdata, cur_wdata);
    end
    if (inf && cyc >= due) begin
      chk("resp_data", COMM_write_data, exp_data);
      chk("resp_len", COMM_write_length, exp_len);
    end
    if (COMM_read_flag) pop_log.push_back(cyc);
    if (COMM_write_flag) begin
      push_cnt++;
      push_cyc = cyc;
      last_push_data = COMM_write_data;
      last_push_len  = COMM_write_length;
      push_log.push_back(COMM_write_data[31:0]);
    end
    if (ram_we != 4'h0) begin
      we_cnt++;
      last_we = ram_we;
    end
    // the write lands on the edge closing the write cycle
    if (inf && cur_kind == K_WR && cyc == pop_cyc + 3) begin
      w = ref_rd(cur_addr / 4);
      for (int b = 0; b < 4; b++)
        if (cur_mask[b]) w[8*b +: 8] = cur_wdata[8*b +: 8];
      mref[cur_addr / 4] = w;
    end
    if (exp_wf) inf = 1'b0;
    if (exp_rf && req_q.size() > 0) model_accept(req_q.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst = rst_req;
    if (rand_wr) COMM_writable = ($urandom_range(0, 9) < 7);
    else         COMM_writable = wr_en;
    if (req_q.size() > 0 && (!rand_wr || $urandom_range(0, 3) != 0)) begin
      COMM_readable    = 1'b1;
      COMM_read_data   = req_q[0].data;
      COMM_read_length = req_q[0].len;
    end else begin
      COMM_readable    = 1'b0;
      COMM_read_data   = '0;
      COMM_read_length = '0;
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!inf && req_q.size() == 0) return;
      step();
    end
    tests++;
    fails++;
    $display("FAIL idle_timeout: got still busy after %0d cycles, required idle", limit);
  endtask

  task automatic run_err(input string name, input req_t r);
    we_cnt = 0;
    req_q.push_back(r);
    wait_idle(50);
    chk({name, "_data"}, last_push_data, 72'hFF);
    chk({name, "_len"}, last_push_len, 1);
    chk({name, "_we_cycles"}, we_cnt, 0);
  endtask

  function automatic req_t rand_req();
    int          k;
    logic [31:0] a;
    logic [3:0]  m;
    logic [1:0]  rsv;
    logic [1:0]  op;
    k   = $urandom_range(0, 9);
    a   = 32'($urandom_range(0, 15)) << 2;
    m   = 4'($urandom);
    rsv = 2'($urandom);
    op  = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    case (k)
      0, 1, 2, 3: return mk({m, rsv, 2'b01}, a, $urandom, 5'd5);
      4, 5, 6:    return mk({m, rsv, 2'b10}, a, $urandom, 5'd9);
      7:          return mk({m, rsv, op}, a | 32'($urandom_range(1, 3)), $urandom,
                            (op == 2'b01) ? 5'd5 : 5'd9);
      8:          return mk({m, rsv, op}, a | (32'h1 << $urandom_range(AB + 2, 31)), $urandom,
                            (op == 2'b01) ? 5'd5 : 5'd9);
      default: begin
        case ($urandom_range(0, 3))
          0: return mk({m, rsv, 2'b00}, a, $urandom, 5'd5);
          1: return mk({m, rsv, 2'b11}, a, $urandom, 5'd9);
          2: return mk({m, rsv, 2'b01}, a, $urandom, 5'd9);
          default: return mk({m, rsv, 2'b10}, a, $urandom, 5'($urandom_range(0, 8)));
        endcase
      end
    endcase
  endfunction

  initial begin
    int   pcnt0;
    logic found;

    rst = 1'b1;
    rst_req = 1'b1;
    wr_en = 1'b1;
    rand_wr = 1'b0;
    COMM_writable = 1'b1;
    COMM_readable = 1'b1;
    COMM_read_data = {72{1'b1}};
    COMM_read_length = 5'd5;
    #3;
    chk_reset_outputs("init");

    rst_req = 1'b0;
    step();
    step();

    // write then read back
    we_cnt = 0;
    req_q.push_back(mk_write(32'h10, 32'hDEADBEEF, 4'hF));
    wait_idle(50);
    chk("w1_we_cycles", we_cnt, 1);
    chk("w1_we_val", last_we, 4'hF);
    chk("w1_resp_data", last_push_data, 0);
    chk("w1_resp_len", last_push_len, 1);
    req_q.push_back(mk_read(32'h10));
    wait_idle(50);
    chk("r1_resp_data", last_push_data, 72'hDEADBEEF);
    chk("r1_resp_len", last_push_len, 4);

    // partial byte mask
    req_q.push_back(mk_write(32'h10, 32'h11223344, 4'h3));
    wait_idle(50);
    req_q.push_back(mk_read(32'h10));
    wait_idle(50);
    chk("r2_partial", last_push_data, 72'hDEAD3344);

    // zero mask writes nothing
    req_q.push_back(mk_write(32'h10, 32'h99999999, 4'h0));
    wait_idle(50);
    req_q.push_back(mk_read(32'h10));
    wait_idle(50);
    chk("r3_mask0", last_push_data, 72'hDEAD3344);

    // error cases
    run_err("err_misaligned", mk_read(32'h12));
    run_err("err_op11", mk(8'hF3, 32'h10, 32'h0, 5'd5));
    run_err("err_wr_len5", mk(8'hF2, 32'h10, 32'h0, 5'd5));
    run_err("err_range", mk_read(32'h1 << (AB + 2)));

    // highest valid word is in range
    req_q.push_back(mk_read((32'h1 << (AB + 2)) - 32'd4));
    wait_idle(50);
    chk("top_read_len", last_push_len, 4);
    chk("top_read_data", last_push_data, 0);

    // two queued reads on an always-writable channel
    req_q.push_back(mk_write(32'h20, 32'hCAFEF00D, 4'hF));
    wait_idle(50);
    pop_log.delete();
    push_log.delete();
    req_q.push_back(mk_read(32'h10));
    req_q.push_back(mk_read(32'h20));
    wait_idle(50);
    chk("q2_pops", pop_log.size(), 2);
    chk("q2_pushes", push_log.size(), 2);
    if (pop_log.size() == 2) chk("q2_pop_gap", pop_log[1] - pop_log[0], 5);
    if (push_log.size() == 2) begin
      chk("q2_first", push_log[0], 32'hDEAD3344);
      chk("q2_second", push_log[1], 32'hCAFEF00D);
    end

    // back-pressure
    wr_en = 1'b0;
    pop_log.delete();
    pcnt0 = push_cnt;
    req_q.push_back(mk_read(32'h20));
    req_q.push_back(mk_read(32'h10));
    for (int i = 0; i < 24; i++) step();
    chk("bp_no_push", push_cnt - pcnt0, 0);
    chk("bp_single_pop", pop_log.size(), 1);
    wr_en = 1'b1;
    step();
    chk("bp_push_now", push_cnt - pcnt0, 1);
    chk("bp_push_cycle", push_cyc, cyc);
    chk("bp_push_data", last_push_data, 72'hCAFEF00D);
    wait_idle(50);
    chk("bp_second_data", last_push_data, 72'hDEAD3344);

    // reset during the write cycle
    req_q.push_back(mk_write(32'h10, 32'h55555555, 4'hF));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (inf && cur_kind == K_WR && cyc == pop_cyc + 2) found = 1'b1;
    end
    if (found) begin
      #2;
      rst = 1'b1;
      rst_req = 1'b1;
      #1;
      chk_reset_outputs("mid_write");
      pcnt0 = push_cnt;
      step();
      step();
      rst_req = 1'b0;
      step();
      step();
      chk("rst_no_push", push_cnt - pcnt0, 0);
      req_q.push_back(mk_read(32'h10));
      wait_idle(50);
      chk("rst_no_write", last_push_data, 72'hDEAD3344);
    end else begin
      tests++;
      fails++;
      $display("FAIL rst_write_cycle: got no write cycle, required one within 20 cycles");
    end

    // randomized stream
    rand_wr = 1'b1;
    for (int i = 0; i < 200; i++) req_q.push_back(rand_req());
    wait_idle(6000);
    rand_wr = 1'b0;
    wr_en = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
